ptw_req_sched: RTL and testbench
================================

Name: ptw_req_sched

Overview:
- Schedules and shares the single hardware page-table walker between three requesters: iside TLB miss, dside TLB miss, and core mark-dirty.
- Each requester's one-shot request is latched, and the scheduler issues one walk at a time using round-robin priority.
- Same-page iside/dside misses merge into one walk.
- Walker completion is routed back to the originating requester(s).
- A watchdog flags stuck walks.
- Sits between the L1 TLB miss logic and the walker.

Parameters:
- TIMEOUT_CYCLES, 4096, walk cycles (BUSY state) before timeout_err is raised; valid range 2..65535.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  iside miss pulse (1 cycle)
- i_va  in  64  iside VA, sampled when i_req=1
- d_req  in  1  dside miss pulse
- d_va  in  64  dside VA, sampled when d_req=1
- dirty_req  in  1  mark-dirty request pulse
- dirty_va  in  64  mark-dirty VA, sampled when dirty_req=1
- flush  in  1  TLB clear; drops pending, unissued iside/dside requests
- walk_valid  out  1  walk request to walker
- walk_va  out  64  VA to walk
- walk_kind  out  2  walk type: 0=iside, 1=dside, 2=dirty
- walk_ready  in  1  walker idle and able to accept a walk
- walk_done  in  1  walker completion pulse (any kind)
- i_done  out  1  iside completion pulse
- d_done  out  1  dside completion pulse
- dirty_done  out  1  dirty completion pulse
- busy  out  1  walk in flight (state ISSUE or BUSY)
- timeout_err  out  1  sticky: a walk exceeded TIMEOUT_CYCLES
- overflow_err  out  1  sticky: a request arrived while the same source was already pending or in flight

Behaviour:
- Reset: all outputs 0; all pending bits cleared; state IDLE; RR pointer = iside; timeout counter 0. A reset mid-walk abandons the walk; later walk_done pulses are ignored while in IDLE.
- Pending latches:
  - Three pending bits, each with a 64-bit VA register.
  - An *_req pulse sets the pending bit and captures the VA in the same edge.
  - If that source is already pending or in flight: the request is dropped, the original VA is kept, and overflow_err is set.
- Arbitration (evaluated in IDLE only):
  - Candidates are the pending bits after this cycle's new requests are applied, so a request can win in the same cycle it arrives.
  - Round-robin order is iside -> dside -> dirty, starting at the RR pointer.
  - The winner's pending bit is cleared and moved into the in-flight set.
  - The RR pointer advances to the source after the winner.
- Merge:
  - If the winner is iside or dside, the other of the two is pending, and va[63:12] matches: both move into the in-flight set.
  - walk_kind is the winner's kind.
  - Dirty walks never merge.
- States:
  - IDLE: any candidate -> ISSUE. Load walk_va/walk_kind and assert walk_valid from the next cycle.
  - ISSUE:
    - walk_valid=1, with walk_va/walk_kind held stable.
    - walk_valid & walk_ready -> BUSY. walk_valid drops the following cycle; timeout counter cleared.
  - BUSY:
    - Counter increments each cycle.
    - walk_done -> IDLE. The in-flight source(s) receive their *_done pulse exactly 1 cycle after walk_done (registered). The in-flight set is cleared.
    - The next issue may start from IDLE in the cycle after walk_done. Minimum walk-to-walk gap is 2 cycles.
    - When the counter reaches TIMEOUT_CYCLES, timeout_err is set. State stays BUSY; the counter saturates.
- walk_done outside BUSY: ignored.
- flush:
  - Clears iside/dside pending bits. Dirty pending is kept.
  - Does not affect ISSUE/BUSY; the in-flight walk still completes and still pulses done.
  - A request arriving in the same cycle as flush is kept, because flush applies before new requests.
- Same-cycle i_req, d_req, dirty_req: all latch; they are serviced over three successive walks in RR order.
- busy = (state != IDLE).

Test Plan:
- Single iside request:
  - i_req, i_va=0x0000_0000_8000_1234; walk_ready=1; walk_done 5 cycles after handshake.
  - Expect walk_valid the cycle after i_req, walk_kind=0, walk_va=0x80001234.
  - Expect i_done exactly 1 cycle after walk_done; d_done/dirty_done stay 0.
- Round-robin fairness:
  - i_req, d_req, dirty_req in the same cycle, then i_req re-asserted immediately after each i_done.
  - Expect issue order iside, dside, dirty, iside; dirty is never starved.
- Merge:
  - i_va=0x4000_5010 and d_va=0x4000_5FF8 pending together.
  - Expect exactly one walk (kind 0); i_done and d_done pulse in the same cycle.
  - Repeat with d_va=0x4000_6000: expect two walks.
- Backpressure and flush:
  - walk_ready=0 for 10 cycles with iside in ISSUE: walk_valid held with a stable VA.
  - flush with a dside request pending: the dside request is never issued and d_done never pulses; the iside walk still completes.
- Timeout:
  - TIMEOUT_CYCLES=8; walk_done withheld.
  - Expect timeout_err=1 after 8 BUSY cycles, state remains BUSY.
  - A later walk_done yields i_done, and timeout_err stays 1.
- Overflow and reset:
  - Second i_req while the iside walk is in flight: overflow_err=1, and the VA in flight is unchanged.
  - reset asserted in BUSY: all outputs 0 next cycle, and a subsequent walk_done produces no done pulse.

Source files
------------

// File: rtl/ptw_req_sched.sv
// Page-table-walker request scheduler: latches iside/dside/dirty requests,
// issues one walk at a time in round-robin order, merges same-page TLB misses.
module ptw_req_sched #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [63:0] i_va,
    input  logic        d_req,
    input  logic [63:0] d_va,
    input  logic        dirty_req,
    input  logic [63:0] dirty_va,
    input  logic        flush,
    output logic        walk_valid,
    output logic [63:0] walk_va,
    output logic [1:0]  walk_kind,
    input  logic        walk_ready,
    input  logic        walk_done,
    output logic        i_done,
    output logic        d_done,
    output logic        dirty_done,
    output logic        busy,
    output logic        timeout_err,
    output logic        overflow_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_t;

    localparam logic [1:0]  SRC_I = 2'd0;
    localparam logic [1:0]  SRC_D = 2'd1;
    localparam logic [1:0]  SRC_W = 2'd2;
    localparam logic [15:0] TMAX  = 16'(TIMEOUT_CYCLES);

    function automatic logic [1:0] rr_next(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  pend_q, pend_d;
    logic [2:0]  infl_q, infl_d;
    logic [2:0]  done_q, done_d;
    logic [1:0]  rr_q, rr_d;
    logic [63:0] va_q [3];
    logic [63:0] va_n [3];
    logic [63:0] wva_q, wva_d;
    logic [1:0]  kind_q, kind_d;
    logic [15:0] cnt_q, cnt_d;
    logic        terr_q, terr_d;
    logic        oerr_q, oerr_d;

    logic [2:0]  req;
    logic [2:0]  kept;
    logic [2:0]  accept;
    logic [2:0]  cand;
    logic [2:0]  grant;
    logic [1:0]  first, second, third;
    logic [1:0]  win;
    logic [1:0]  other;
    logic        win_vld;
    logic        merge;

    assign req = {dirty_req, d_req, i_req};

    // flush lands before this cycle's requests, so a same-cycle miss survives
    assign kept   = pend_q & ~{1'b0, flush, flush};
    assign accept = req & ~kept & ~infl_q;
    assign cand   = kept | accept;

    assign va_n[0] = accept[0] ? i_va     : va_q[0];
    assign va_n[1] = accept[1] ? d_va     : va_q[1];
    assign va_n[2] = accept[2] ? dirty_va : va_q[2];

    always_comb begin
        first  = rr_q;
        second = rr_next(first);
        third  = rr_next(second);
        if (cand[first]) begin
            win = first;
        end else if (cand[second]) begin
            win = second;
        end else begin
            win = third;
        end
    end

    assign win_vld = |cand;
    assign other   = (win == SRC_I) ? SRC_D : SRC_I;

    // only TLB misses on the same 4 KiB page share a walk
    assign merge = (win != SRC_W) && cand[other] &&
                   (va_n[win][63:12] == va_n[other][63:12]);

    assign grant = (3'b001 << win) |
                   ((merge ? 3'b001 : 3'b000) << other);

    always_comb begin
        state_d = state_q;
        pend_d  = cand;
        infl_d  = infl_q;
        done_d  = 3'b000;
        rr_d    = rr_q;
        wva_d   = wva_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;
        oerr_d  = oerr_q | (|(req & (kept | infl_q)));
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = ISSUE;
                    pend_d  = cand & ~grant;
                    infl_d  = grant;
                    rr_d    = rr_next(win);
                    wva_d   = va_n[win];
                    kind_d  = win;
                end
            end
            ISSUE: begin
                if (walk_ready) begin
                    state_d = BUSY;
                    cnt_d   = 16'd0;
                end
            end
            BUSY: begin
                if (cnt_q != TMAX) begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (cnt_q >= TMAX - 16'd1) begin
                    terr_d = 1'b1;
                end
                if (walk_done) begin
                    state_d = IDLE;
                    done_d  = infl_q;
                    infl_d  = 3'b000;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= 3'b000;
            infl_q  <= 3'b000;
            done_q  <= 3'b000;
            rr_q    <= SRC_I;
            wva_q   <= 64'd0;
            kind_q  <= 2'd0;
            cnt_q   <= 16'd0;
            terr_q  <= 1'b0;
            oerr_q  <= 1'b0;
            for (int s = 0; s < 3; s++) begin
                va_q[s] <= 64'd0;
            end
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            infl_q  <= infl_d;
            done_q  <= done_d;
            rr_q    <= rr_d;
            wva_q   <= wva_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
            oerr_q  <= oerr_d;
            for (int s = 0; s < 3; s++) begin
                va_q[s] <= va_n[s];
            end
        end
    end

    assign walk_valid   = (state_q == ISSUE);
    assign busy         = (state_q != IDLE);
    assign walk_va      = wva_q;
    assign walk_kind    = kind_q;
    assign i_done       = done_q[0];
    assign d_done       = done_q[1];
    assign dirty_done   = done_q[2];
    assign timeout_err  = terr_q;
    assign overflow_err = oerr_q;

endmodule

// File: tb/tb_ptw_req_sched.sv
// Bench for ptw_req_sched: vector table, directed corner sequences and a
// random run checked cycle by cycle against a behavioural scheduler model.
module tb_ptw_req_sched;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, dirty_req = 1'b0;
    logic [63:0] i_va = '0, d_va = '0, dirty_va = '0;
    logic        flush = 1'b0, walk_ready = 1'b0, walk_done = 1'b0;
    logic        walk_valid;
    logic [63:0] walk_va;
    logic [1:0]  walk_kind;
    logic        i_done, d_done, dirty_done, busy, timeout_err, overflow_err;

    int nvec = 0;
    int nbad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ptw_req_sched #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_va(i_va),
        .d_req(d_req), .d_va(d_va),
        .dirty_req(dirty_req), .dirty_va(dirty_va),
        .flush(flush),
        .walk_valid(walk_valid), .walk_va(walk_va), .walk_kind(walk_kind),
        .walk_ready(walk_ready), .walk_done(walk_done),
        .i_done(i_done), .d_done(d_done), .dirty_done(dirty_done),
        .busy(busy), .timeout_err(timeout_err), .overflow_err(overflow_err)
    );

    // Behavioural model: 0 = idle, 1 = offering a walk, 2 = walk running
    int          m_state = 0;
    bit          m_pend [3];
    bit          m_infl [3];
    logic [63:0] m_va [3];
    int          m_rr = 0;
    int          m_cnt = 0;
    logic [63:0] m_wva = '0;
    int          m_kind = 0;
    bit [2:0]    m_done = '0;
    bit          m_terr = 0, m_oerr = 0;

    always @(posedge clk) begin
        bit          r [3];
        logic [63:0] v [3];
        int          w;
        r = '{i_req, d_req, dirty_req};
        v = '{i_va, d_va, dirty_va};
        m_done = '0;
        if (reset) begin
            m_state = 0; m_rr = 0; m_cnt = 0; m_wva = '0; m_kind = 0;
            m_terr = 0; m_oerr = 0;
            for (int s = 0; s < 3; s++) begin
                m_pend[s] = 0; m_infl[s] = 0;
            end
        end else begin
            if (flush) begin
                m_pend[0] = 0; m_pend[1] = 0;
            end
            for (int s = 0; s < 3; s++) begin
                if (r[s]) begin
                    if (m_pend[s] || m_infl[s]) m_oerr = 1;
                    else begin m_pend[s] = 1; m_va[s] = v[s]; end
                end
            end
            case (m_state)
                0: begin
                    w = -1;
                    for (int k = 0; k < 3; k++)
                        if (w < 0 && m_pend[(m_rr + k) % 3]) w = (m_rr + k) % 3;
                    if (w >= 0) begin
                        m_pend[w] = 0; m_infl[w] = 1;
                        m_wva = m_va[w]; m_kind = w;
                        m_rr = (w + 1) % 3; m_state = 1;
                        if (w < 2 && m_pend[1-w] &&
                            m_va[1-w][63:12] == m_wva[63:12]) begin
                            m_pend[1-w] = 0; m_infl[1-w] = 1;
                        end
                    end
                end
                1: if (walk_ready) begin m_state = 2; m_cnt = 0; end
                default: begin
                    if (m_cnt < T) m_cnt++;
                    if (m_cnt >= T) m_terr = 1;
                    if (walk_done) begin
                        for (int s = 0; s < 3; s++) begin
                            m_done[s] = m_infl[s]; m_infl[s] = 0;
                        end
                        m_state = 0;
                    end
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic model_cmp();
        if (chk_en)
            check("model",
                  {walk_valid, busy, walk_kind, walk_va, i_done, d_done,
                   dirty_done, timeout_err, overflow_err},
                  {m_state == 1, m_state != 0, 2'(m_kind), m_wva, m_done[0],
                   m_done[1], m_done[2], m_terr, m_oerr});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_cmp();
    endtask

    task automatic clear_in();
        reset = 0; i_req = 0; d_req = 0; dirty_req = 0;
        flush = 0; walk_done = 0;
    endtask

    task automatic serve(input int lat, output int kind, output bit ok);
        int n = 0;
        ok = 0; kind = 3;
        while (!walk_valid && n < 40) begin step(); n++; end
        if (!walk_valid) begin
            check("serve_wait", 1, 0);
            return;
        end
        kind = int'(walk_kind); ok = 1;
        walk_ready = 1; step();
        repeat (lat) step();
        walk_done = 1; step(); walk_done = 0;
    endtask

    function automatic logic [63:0] rand_va();
        logic [63:0] pg [3];
        pg = '{64'h0000_0000_4000_5000, 64'h8000_0000_4000_5000,
               64'h0000_0000_4000_6000};
        return pg[$urandom_range(0, 2)] | 64'($urandom_range(0, 4095));
    endfunction

    typedef struct {
        bit          rst;
        bit          ir;
        logic [63:0] iv;
        bit          dr;
        logic [63:0] dv;
        bit          rdy;
        bit          dn;
        bit          ev;
        logic [1:0]  ek;
        logic [63:0] eva;
        bit [2:0]    ed;
    } vec_t;

    function automatic vec_t V(bit rst, bit ir, logic [63:0] iv, bit dr,
                               logic [63:0] dv, bit rdy, bit dn, bit ev,
                               logic [1:0] ek, logic [63:0] eva, bit [2:0] ed);
        vec_t x;
        x = '{rst, ir, iv, dr, dv, rdy, dn, ev, ek, eva, ed};
        return x;
    endfunction

    initial begin
        vec_t        tbl [$];
        int          k;
        bit          ok, flag;
        logic [7:0]  ord;
        logic [63:0] A  = 64'h0000_0000_8000_1234;
        logic [63:0] M1 = 64'h0000_0000_4000_5010;
        logic [63:0] M2 = 64'h0000_0000_4000_5FF8;
        logic [63:0] M3 = 64'h0000_0000_4000_6000;

        // single iside walk, done 5 cycles after the handshake
        tbl.push_back(V(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        tbl.push_back(V(0, 1, A, 0, 0, 1, 0, 1, 0, A, 3'b000));
        for (int j = 0; j < 5; j++)
            tbl.push_back(V(0, 0, 0, 0, 0, 1, 0, 0, 0, A, 3'b000));
        tbl.push_back(V(0, 0, 0, 0, 0, 1, 1, 0, 0, A, 3'b001));
        tbl.push_back(V(0, 0, 0, 0, 0, 1, 0, 0, 0, A, 3'b000));
        // same-page merge
        tbl.push_back(V(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        tbl.push_back(V(0, 1, M1, 1, M2, 0, 0, 1, 0, M1, 3'b000));
        tbl.push_back(V(0, 0, 0, 0, 0, 1, 0, 0, 0, M1, 3'b000));
        tbl.push_back(V(0, 0, 0, 0, 0, 1, 1, 0, 0, M1, 3'b011));
        tbl.push_back(V(0, 0, 0, 0, 0, 1, 0, 0, 0, M1, 3'b000));
        // different pages: two walks
        tbl.push_back(V(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        tbl.push_back(V(0, 1, M1, 1, M3, 1, 0, 1, 0, M1, 3'b000));
        tbl.push_back(V(0, 0, 0, 0, 0, 1, 0, 0, 0, M1, 3'b000));
        tbl.push_back(V(0, 0, 0, 0, 0, 1, 1, 0, 0, M1, 3'b001));
        tbl.push_back(V(0, 0, 0, 0, 0, 1, 0, 1, 1, M3, 3'b000));
        tbl.push_back(V(0, 0, 0, 0, 0, 1, 0, 0, 1, M3, 3'b000));
        tbl.push_back(V(0, 0, 0, 0, 0, 1, 1, 0, 1, M3, 3'b010));
        tbl.push_back(V(0, 0, 0, 0, 0, 1, 0, 0, 1, M3, 3'b000));

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1;

        k = 0;
        foreach (tbl[j]) begin
            reset = tbl[j].rst; i_req = tbl[j].ir; i_va = tbl[j].iv;
            d_req = tbl[j].dr; d_va = tbl[j].dv;
            walk_ready = tbl[j].rdy; walk_done = tbl[j].dn;
            step();
            check($sformatf("table_row%0d", j),
                  {walk_valid, walk_kind, walk_va, dirty_done, d_done, i_done},
                  {tbl[j].ev, tbl[j].ek, tbl[j].eva, tbl[j].ed});
        end
        clear_in();

        // round robin with all three arriving together
        reset = 1; step(); reset = 0;
        walk_ready = 1;
        i_req = 1; d_req = 1; dirty_req = 1;
        i_va = 64'h1000; d_va = 64'h2000_0000; dirty_va = 64'h3000;
        step(); clear_in();
        ord = '0;
        for (int n = 0; n < 4; n++) begin
            serve(2, k, ok);
            ord = {ord[5:0], 2'(k)};
            if (ok)
                check("rr_done", {dirty_done, d_done, i_done},
                      3'b001 << k);
            if (i_done && n < 3) begin
                i_req = 1; i_va = 64'h5000; step(); i_req = 0;
            end
        end
        check("rr_order", ord, 8'b00_01_10_00);

        // backpressure, then flush drops the queued dside miss
        reset = 1; step(); reset = 0; walk_ready = 0;
        i_req = 1; i_va = 64'hABCD_E000_0123; step(); i_req = 0;
        d_req = 1; d_va = 64'h7777_0000; step(); d_req = 0;
        flag = 1;
        for (int n = 0; n < 10; n++) begin
            if (!(walk_valid && walk_va == 64'hABCD_E000_0123 &&
                  walk_kind == 2'd0)) flag = 0;
            step();
        end
        check("bp_hold", flag, 1);
        flush = 1; step(); flush = 0;
        serve(3, k, ok);
        check("flush_iwalk", {2'(k), i_done, d_done}, {2'd0, 1'b1, 1'b0});
        flag = 0;
        for (int n = 0; n < 12; n++) begin
            if (walk_valid || d_done) flag = 1;
            step();
        end
        check("flush_drop", flag, 0);

        // watchdog
        reset = 1; step(); reset = 0; walk_ready = 1;
        i_req = 1; i_va = 64'h9000; step(); i_req = 0;
        step();
        repeat (7) step();
        check("to_before", {timeout_err, busy}, 2'b01);
        step();
        check("to_set", {timeout_err, busy}, 2'b11);
        repeat (5) step();
        check("to_hold", {timeout_err, busy}, 2'b11);
        walk_done = 1; step(); walk_done = 0;
        check("to_done", {timeout_err, i_done, busy}, 3'b110);

        // overflow, then reset mid-walk
        reset = 1; step(); reset = 0; walk_ready = 1;
        i_req = 1; i_va = 64'h1111_2000; step(); i_req = 0;
        step();
        check("ovf_clear", {overflow_err, busy}, 2'b01);
        i_req = 1; i_va = 64'h2222_3000; step(); i_req = 0;
        check("ovf_set", {overflow_err, walk_va}, {1'b1, 64'h1111_2000});
        reset = 1; step(); reset = 0;
        check("rst_busy",
              {walk_valid, walk_va, walk_kind, i_done, d_done, dirty_done,
               busy, timeout_err, overflow_err}, '0);
        walk_done = 1; step(); walk_done = 0;
        check("rst_nodone", {i_done, d_done, dirty_done, busy}, 4'b0000);

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            i_req = ($urandom_range(0, 7) == 0);
            d_req = ($urandom_range(0, 7) == 0);
            dirty_req = ($urandom_range(0, 11) == 0);
            i_va = rand_va(); d_va = rand_va(); dirty_va = rand_va();
            flush = ($urandom_range(0, 29) == 0);
            walk_ready = ($urandom_range(0, 9) < 7);
            walk_done = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        clear_in();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
